mu0_control: RTL and testbench
==============================

# mu0_control

Control unit for the MU0 16-bit processor: a fetch/execute sequencer that drives the register enables, datapath multiplexer selects, ALU function and memory strobes for the PC, IR and Acc registers. Sits beside the datapath. Takes the IR opcode and the Acc flags, and produces all datapath control. Also keeps a saturating count of retired instructions for debug and test.

## Interface
- No parameters; all widths fixed by the MU0 ISA.
- Clk  in  1  system clock, rising edge active
- nReset  in  1  asynchronous, active-low reset
- F  in  4  opcode, IR[15:12]
- N  in  1  Acc negative flag, Acc[15]
- Z  in  1  Acc zero flag, Acc == 0
- Mem_Ready  in  1  memory ready; present only with MU0_MEM_WAIT_EN
- X_sel  out  1  ALU X operand: 0 = Acc, 1 = PC
- Y_sel  out  1  ALU Y operand: 0 = memory data, 1 = IR[11:0] zero-extended
- Addr_sel  out  1  memory address: 0 = PC, 1 = IR[11:0]
- ALU_fs  out  2  ALU function: 00 pass Y, 01 X+Y, 10 X+1, 11 X−Y
- PC_En, IR_En, Acc_En  out  1 each  register load enables
- Rd, Wr  out  1 each  memory read and write strobes
- Fetch  out  1  high in the FETCH state
- Halted  out  1  high in the HALT state
- Instr_Count  out  16  retired-instruction count

## Operation
- States: FETCH, EXECUTE, HALT.
- Control outputs are decoded combinationally from the state and F (Moore/Mealy mix).
- FETCH outputs:
  - Addr_sel=0, Rd=1, IR_En=1, X_sel=1, ALU_fs=10, PC_En=1.
  - Effect: IR←mem[PC], PC←PC+1.
  - Next state: EXECUTE.
- EXECUTE outputs, by F:
  - 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, ALU_fs=00, Acc_En=1.
  - 1 STA: Addr_sel=1, Wr=1, X_sel=0 (Acc drives write data).
  - 2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, ALU_fs=01, Acc_En=1.
  - 3 SUB: same as ADD, with ALU_fs=11.
  - 4 JMP: Y_sel=1, ALU_fs=00, PC_En=1.
  - 5 JGE: as JMP, but PC_En=~N.
  - 6 JNE: as JMP, but PC_En=~Z.
  - 7 STP: no enables, no strobes.
  - 8–15: treated as no-operation; no enables, no strobes.
- EXECUTE next state: HALT if F=7; otherwise FETCH.
- HALT:
  - All enables and strobes are 0; Halted=1.
  - Leaves HALT only via nReset.
- Unlisted outputs default to 0.
- Rd and Wr are never high together.
- Instr_Count:
  - Increments on every edge that leaves EXECUTE, including STP and undefined opcodes.
  - Saturates at 16'hFFFF; no wrap-around.
- Reset values (while nReset low and after release):
  - State=FETCH, Instr_Count=0.
  - All enables, Rd and Wr forced to 0 while nReset is low.
  - Fetch=1, Halted=0.
- Reset mid-instruction: the instruction is abandoned, the count is not incremented, and the first rising edge after release performs a FETCH.

## Timing
- Two cycles per instruction, with no wait states.
- Register loads occur on the Clk edge that ends the cycle asserting the enable.
- STP: Halted=1 from the cycle following its EXECUTE cycle.
- Instr_Count reflects an instruction from the cycle after its EXECUTE.
- nReset assertion takes effect immediately (asynchronous). Deassertion is synchronised externally; no synchroniser inside the block.

## Configuration
- MU0_MEM_WAIT_EN defined:
  - The Mem_Ready port exists.
  - In any cycle with Rd or Wr high and Mem_Ready=0:
    - The state holds.
    - PC_En, IR_En and Acc_En are forced to 0.
    - Rd/Wr, Addr_sel and the other selects stay stable.
    - Instr_Count does not change.
  - The cycle completes normally on the first cycle with Mem_Ready=1.
  - Mem_Ready is ignored in cycles with no strobe.
- MU0_MEM_WAIT_EN undefined: no Mem_Ready port; every memory access completes in one cycle.

## Structure
- Package mu0_pkg holds:
  - Opcode constants LDA..STP (0–7).
  - State encoding: FETCH=2'b00, EXECUTE=2'b01, HALT=2'b10.
  - ALU_fs codes.
- Sub-module mu0_decode: combinational; maps (state, F, N, Z) to the control vector.
- mu0_control holds the state register, the next-state logic, the wait gating and Instr_Count.

## Test plan
- Reset then release, F=0 → cycle 1: Fetch=1, Rd=1, IR_En=1, PC_En=1, ALU_fs=10 → cycle 2: Addr_sel=1, Acc_En=1, ALU_fs=00 → Instr_Count=1.
- F=5 with N=1 in EXECUTE → PC_En=0; with N=0 → PC_En=1, Y_sel=1. Repeat for F=6 with Z.
- F=7 → HALT next cycle, Halted=1, all enables 0 for 20 cycles; pulse nReset low → Fetch=1, Instr_Count=0.
- Force Instr_Count to 16'hFFFE and execute 3 instructions → count holds at 16'hFFFF.
- F=1 in EXECUTE → Wr=1, Rd=0, X_sel=0; F=12 → no strobes, next state FETCH.
- With MU0_MEM_WAIT_EN, Mem_Ready=0 for 3 cycles during an LDA execute → state held, Acc_En=0, Rd=1 held; Mem_Ready=1 → Acc_En=1, then FETCH.

Source files
------------

// File: rtl/mu0_pkg.sv
// ============================================================================
// Module : mu0_pkg
// Brief  : Shared types and constants for the MU0 control unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mu0_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        HALT    = 2'b10
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_PASS_Y = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_INC_X  = 2'b10;
    localparam logic [1:0] ALU_SUB    = 2'b11;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic [1:0] alu_fs;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic       rd;
        logic       wr;
    } ctrl_t;

    // Retired-instruction counter sticks at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mu0_if.sv
// ============================================================================
// Module : mu0_if
// Brief  : Control/datapath bundle; Mem_Ready exists only with MU0_MEM_WAIT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mu0_if;

    logic [3:0]  F;
    logic        N;
    logic        Z;
`ifdef MU0_MEM_WAIT_EN
    logic        Mem_Ready;
`endif
    logic        X_sel;
    logic        Y_sel;
    logic        Addr_sel;
    logic [1:0]  ALU_fs;
    logic        PC_En;
    logic        IR_En;
    logic        Acc_En;
    logic        Rd;
    logic        Wr;
    logic        Fetch;
    logic        Halted;
    logic [15:0] Instr_Count;

`ifdef MU0_MEM_WAIT_EN
    modport master (
        input  F, N, Z, Mem_Ready,
        output X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En,
               Rd, Wr, Fetch, Halted, Instr_Count
    );
    modport slave (
        output F, N, Z, Mem_Ready,
        input  X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En,
               Rd, Wr, Fetch, Halted, Instr_Count
    );
`else
    modport master (
        input  F, N, Z,
        output X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En,
               Rd, Wr, Fetch, Halted, Instr_Count
    );
    modport slave (
        output F, N, Z,
        input  X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En,
               Rd, Wr, Fetch, Halted, Instr_Count
    );
`endif

endinterface

`default_nettype wire

// File: rtl/mu0_decode.sv
// ============================================================================
// Module : mu0_decode
// Brief  : Combinational map from (state, opcode, flags) to the control vector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mu0_decode
    import mu0_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.addr_sel = 1'b0;
                ctrl.rd       = 1'b1;
                ctrl.ir_en    = 1'b1;
                ctrl.x_sel    = 1'b1;
                ctrl.alu_fs   = ALU_INC_X;
                ctrl.pc_en    = 1'b1;
            end
            EXECUTE: begin
                case (f)
                    OP_LDA: begin
                        ctrl.addr_sel = 1'b1;
                        ctrl.rd       = 1'b1;
                        ctrl.alu_fs   = ALU_PASS_Y;
                        ctrl.acc_en   = 1'b1;
                    end
                    OP_STA: begin
                        // Acc reaches the write-data path through the X operand.
                        ctrl.addr_sel = 1'b1;
                        ctrl.wr       = 1'b1;
                        ctrl.x_sel    = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.addr_sel = 1'b1;
                        ctrl.rd       = 1'b1;
                        ctrl.alu_fs   = (f == OP_ADD) ? ALU_ADD : ALU_SUB;
                        ctrl.acc_en   = 1'b1;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        ctrl.y_sel  = 1'b1;
                        ctrl.alu_fs = ALU_PASS_Y;
                        ctrl.pc_en  = (f == OP_JMP) ? 1'b1 :
                                      (f == OP_JGE) ? ~n   : ~z;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mu0_control.sv
// ============================================================================
// Module : mu0_control
// Brief  : MU0 fetch/execute sequencer with saturating retired-instruction count.
//          Optional memory wait states enabled by defining MU0_MEM_WAIT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mu0_control
    import mu0_pkg::*;
(
    input  logic      Clk,
    input  logic      nReset,
    mu0_if.master     bus
);

    state_t      r_state;
    state_t      w_next_state;
    ctrl_t       w_dec;
    logic        w_stall;
    logic        w_load_ok;
    logic [15:0] r_count;

    mu0_decode u_decode (
        .state (r_state),
        .f     (bus.F),
        .n     (bus.N),
        .z     (bus.Z),
        .ctrl  (w_dec)
    );

`ifdef MU0_MEM_WAIT_EN
    assign w_stall = (w_dec.rd | w_dec.wr) & ~bus.Mem_Ready;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!w_stall) begin
            case (r_state)
                FETCH:   w_next_state = EXECUTE;
                EXECUTE: w_next_state = (bus.F == OP_STP) ? HALT : FETCH;
                HALT:    w_next_state = HALT;
                default: w_next_state = FETCH;
            endcase
        end
    end

    // A retirement is the completing edge of EXECUTE, whatever the opcode.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_count <= 16'd0;
        end else if (r_state == EXECUTE && !w_stall) begin
            r_count <= sat_inc(r_count);
        end
    end

    // Enables are gated asynchronously so nothing loads while reset is held.
    assign w_load_ok = nReset & ~w_stall;

    assign bus.X_sel       = w_dec.x_sel;
    assign bus.Y_sel       = w_dec.y_sel;
    assign bus.Addr_sel    = w_dec.addr_sel;
    assign bus.ALU_fs      = w_dec.alu_fs;
    assign bus.PC_En       = w_dec.pc_en  & w_load_ok;
    assign bus.IR_En       = w_dec.ir_en  & w_load_ok;
    assign bus.Acc_En      = w_dec.acc_en & w_load_ok;
    assign bus.Rd          = w_dec.rd & nReset;
    assign bus.Wr          = w_dec.wr & nReset;
    assign bus.Fetch       = (r_state == FETCH);
    assign bus.Halted      = (r_state == HALT);
    assign bus.Instr_Count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mu0_control.sv
// ============================================================================
// Module : tb_mu0_control
// Brief  : Scoreboard bench for mu0_control; expected vectors come from a
//          reference model of the instruction table. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mu0_control;
    import mu0_pkg::*;

    logic Clk = 1'b0;
    logic nReset = 1'b0;

    mu0_if bus();

    mu0_control dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] ctrl;
        logic [15:0] count;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    state_t      m_state = FETCH;
    logic [15:0] m_count = 16'd0;

    // Vector layout: Fetch Halted X Y Addr ALU[1:0] PC IR Acc Rd Wr
    function automatic logic [11:0] model_ctrl(input state_t st, input logic [3:0] f,
                                               input logic n, input logic z);
        case (st)
            FETCH:   return 12'b1_0_1_0_0_10_1_1_0_1_0;
            HALT:    return 12'b0_1_0_0_0_00_0_0_0_0_0;
            default: begin
                case (f)
                    4'd0: return 12'b0_0_0_0_1_00_0_0_1_1_0;
                    4'd1: return 12'b0_0_0_0_1_00_0_0_0_0_1;
                    4'd2: return 12'b0_0_0_0_1_01_0_0_1_1_0;
                    4'd3: return 12'b0_0_0_0_1_11_0_0_1_1_0;
                    4'd4: return 12'b0_0_0_1_0_00_1_0_0_0_0;
                    4'd5: return {7'b0_0_0_1_0_00, ~n, 4'b0_0_0_0};
                    4'd6: return {7'b0_0_0_1_0_00, ~z, 4'b0_0_0_0};
                    default: return 12'b0;
                endcase
            end
        endcase
    endfunction

    function automatic logic [11:0] obs();
        return {bus.Fetch, bus.Halted, bus.X_sel, bus.Y_sel, bus.Addr_sel, bus.ALU_fs,
                bus.PC_En, bus.IR_En, bus.Acc_En, bus.Rd, bus.Wr};
    endfunction

    // Drive one cycle at the falling edge, push its expectation, advance the model.
    task automatic drive(input logic [3:0] f, input logic n = 1'b0, input logic z = 1'b0,
                         input logic rst = 1'b1, input logic mr = 1'b1);
        logic [11:0] exp_c;
        logic        stall;
        @(negedge Clk);
        bus.F  = f;
        bus.N  = n;
        bus.Z  = z;
        nReset = rst;
`ifdef MU0_MEM_WAIT_EN
        bus.Mem_Ready = mr;
`endif
        if (!rst) begin
            m_state = FETCH;
            m_count = 16'd0;
        end
        exp_c = model_ctrl(m_state, f, n, z);
        stall = 1'b0;
`ifdef MU0_MEM_WAIT_EN
        stall = (exp_c[1] | exp_c[0]) & ~mr;
`endif
        if (!rst) exp_c[4:0] = 5'b0;
        if (stall) exp_c[4:2] = 3'b0;
        sb.push_back('{exp_c, m_count});
        if (rst && !stall) begin
            if (m_state == EXECUTE && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            case (m_state)
                FETCH:   m_state = EXECUTE;
                EXECUTE: m_state = (f == 4'd7) ? HALT : FETCH;
                default: m_state = HALT;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(4'd0, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.ctrl) begin
                n_fail++;
                $display("FAIL reset_ctrl c%0d got=%b exp=%b", i, obs(), e.ctrl);
            end
            n_tests++;
            if (bus.Instr_Count !== e.count) begin
                n_fail++;
                $display("FAIL reset_count c%0d got=%h exp=%h", i, bus.Instr_Count, e.count);
            end
        end
    endtask

    task automatic test_lda();
        for (int i = 0; i < 3; i++) begin
            drive(4'd0);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.ctrl) begin
                n_fail++;
                $display("FAIL lda_ctrl c%0d got=%b exp=%b", i, obs(), e.ctrl);
            end
            n_tests++;
            if (bus.Instr_Count !== e.count) begin
                n_fail++;
                $display("FAIL lda_count c%0d got=%h exp=%h", i, bus.Instr_Count, e.count);
            end
        end
        // Finish the trailing instruction so the next test starts in FETCH.
        drive(4'd0);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e.ctrl) begin
            n_fail++;
            $display("FAIL lda_tail got=%b exp=%b", obs(), e.ctrl);
        end
    endtask

    task automatic test_jumps();
        logic [3:0] fs[4] = '{4'd5, 4'd5, 4'd6, 4'd6};
        logic       fl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                drive(fs[k], fl[k], fl[k]);
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL jump_ctrl f=%0d flag=%0d c%0d got=%b exp=%b",
                             fs[k], fl[k], c, obs(), e.ctrl);
                end
            end
        end
    endtask

    task automatic test_sta_nop();
        logic [3:0] fs[4] = '{4'd1, 4'd12, 4'd8, 4'd15};
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                drive(fs[k], 1'b1, 1'b1);
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL sta_nop_ctrl f=%0d c%0d got=%b exp=%b", fs[k], c, obs(), e.ctrl);
                end
                n_tests++;
                if (bus.Instr_Count !== e.count) begin
                    n_fail++;
                    $display("FAIL sta_nop_count f=%0d c%0d got=%h exp=%h",
                             fs[k], c, bus.Instr_Count, e.count);
                end
            end
        end
    endtask

    task automatic test_saturate();
        @(posedge Clk);
        #2;
        force dut.r_count = 16'hFFFE;
        #1;
        release dut.r_count;
        m_count = 16'hFFFE;
        for (int i = 0; i < 8; i++) begin
            drive(4'd2 + 4'(i % 2));
            e = sb.pop_front();
            n_tests++;
            if (bus.Instr_Count !== e.count) begin
                n_fail++;
                $display("FAIL sat_count c%0d got=%h exp=%h", i, bus.Instr_Count, e.count);
            end
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 24; i++) begin
            if (i < 2)       drive(4'd7);
            else if (i < 22) drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
            else             drive(4'd0, 1'b0, 1'b0, (i == 23));
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.ctrl) begin
                n_fail++;
                $display("FAIL halt_ctrl c%0d got=%b exp=%b", i, obs(), e.ctrl);
            end
            n_tests++;
            if (bus.Instr_Count !== e.count) begin
                n_fail++;
                $display("FAIL halt_count c%0d got=%h exp=%h", i, bus.Instr_Count, e.count);
            end
        end
        drive(4'd0);
        e = sb.pop_front();
    endtask

    task automatic test_mid_reset();
        logic [3:0] fs[5] = '{4'd9, 4'd9, 4'd2, 4'd2, 4'd0};
        logic       rs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(fs[i], 1'b0, 1'b0, rs[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.ctrl) begin
                n_fail++;
                $display("FAIL midrst_ctrl c%0d got=%b exp=%b", i, obs(), e.ctrl);
            end
            n_tests++;
            if (bus.Instr_Count !== e.count) begin
                n_fail++;
                $display("FAIL midrst_count c%0d got=%h exp=%h", i, bus.Instr_Count, e.count);
            end
        end
        drive(4'd0);
        e = sb.pop_front();
    endtask

    task automatic test_back_to_back();
        logic [3:0] f;
        logic       n, z;
        for (int i = 0; i < 30; i++) begin
            f = 4'($urandom_range(0, 15));
            if (f == 4'd7) f = 4'd4;
            n = 1'($urandom);
            z = 1'($urandom);
            for (int c = 0; c < 2; c++) begin
                drive(f, n, z);
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.ctrl || bus.Instr_Count !== e.count) begin
                    n_fail++;
                    $display("FAIL b2b i%0d c%0d f=%0d got=%b/%h exp=%b/%h",
                             i, c, f, obs(), bus.Instr_Count, e.ctrl, e.count);
                end
                n_tests++;
                if (bus.Rd === 1'b1 && bus.Wr === 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_rdwr i%0d c%0d got=11 exp=not both", i, c);
                end
            end
        end
    endtask

`ifdef MU0_MEM_WAIT_EN
    task automatic test_mem_wait();
        logic mrs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(4'd0, 1'b0, 1'b0, 1'b1, mrs[i]);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e.ctrl || bus.Instr_Count !== e.count) begin
                n_fail++;
                $display("FAIL memwait c%0d got=%b/%h exp=%b/%h",
                         i, obs(), bus.Instr_Count, e.ctrl, e.count);
            end
        end
        drive(4'd0);
        e = sb.pop_front();
    endtask
`endif

    initial begin
        bus.F = 4'd0;
        bus.N = 1'b0;
        bus.Z = 1'b0;
`ifdef MU0_MEM_WAIT_EN
        bus.Mem_Ready = 1'b1;
`endif
        test_reset();
        test_lda();
        test_jumps();
        test_sta_nop();
        test_saturate();
        test_halt();
        test_mid_reset();
        test_back_to_back();
`ifdef MU0_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
